// File: rtl/sprite_render.sv
// Sprite overlay pixel stage: maps the beam position to a 32x32 sprite ROM address,
// applies the transparency key and merges the sprite over the background pixel.
// Latency is 3 clocks from the beam inputs to pix_out; throughput is one pixel per clock.
module sprite_render #(
    parameter int unsigned SPR_W_LOG2  = 5,
    parameter int unsigned SPR_H_LOG2  = 5,
    parameter logic [7:0]  TRANSPARENT = 8'hE3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [9:0]                       hcount,
    input  logic [9:0]                       vcount,
    input  logic                             blank,
    input  logic                             frame_start,
    input  logic [7:0]                       bg_pixel,
    input  logic [9:0]                       pos_x,
    input  logic [9:0]                       pos_y,
    input  logic                             pos_load,
    input  logic                             spr_en,
    output logic [SPR_H_LOG2+SPR_W_LOG2-1:0] rom_addr,
    input  logic [7:0]                       rom_data,
    output logic [7:0]                       pix_out,
    output logic                             pix_blank,
    output logic                             spr_hit
);

    localparam int unsigned AddrW = SPR_H_LOG2 + SPR_W_LOG2;
    localparam logic [10:0] SprW  = 11'(1 << SPR_W_LOG2);
    localparam logic [10:0] SprH  = 11'(1 << SPR_H_LOG2);

    // Position registers: shadow is written by software at any time, active is what the
    // hit test uses and only changes at a frame boundary.
    logic [9:0] shadow_x_q, shadow_x_d;
    logic [9:0] shadow_y_q, shadow_y_d;
    logic [9:0] act_x_q, act_x_d;
    logic [9:0] act_y_q, act_y_d;
    logic       act_en_q, act_en_d;

    // Stage 0 (combinational hit test)
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_box;

    // Stage 1 / stage 2 pipeline registers
    logic [AddrW-1:0] rom_addr_q, rom_addr_d;
    logic             s1_in_box_q;
    logic [7:0]       s1_bg_q;
    logic             s1_blank_q;
    logic             s2_in_box_q;
    logic [7:0]       s2_bg_q;
    logic             s2_blank_q;

    // Stage 3 output registers
    logic [7:0] pix_out_q, pix_out_d;
    logic       pix_blank_q;
    logic       spr_hit_q, spr_hit_d;
    logic       opaque;

    // Next-state for the double-buffered position and enable
    always_comb begin
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        act_x_d    = act_x_q;
        act_y_d    = act_y_q;
        act_en_d   = act_en_q;
        if (pos_load) begin
            shadow_x_d = pos_x;
            shadow_y_d = pos_y;
        end
        if (frame_start) begin
            // A load coinciding with frame_start bypasses the shadow so it is not lost
            act_x_d  = pos_load ? pos_x : shadow_x_q;
            act_y_d  = pos_load ? pos_y : shadow_y_q;
            act_en_d = spr_en;
        end
    end

    // Position and enable state
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_x_q <= '0;
            shadow_y_q <= '0;
            act_x_q    <= '0;
            act_y_q    <= '0;
            act_en_q   <= 1'b0;
        end else begin
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            act_en_q   <= act_en_d;
        end
    end

    // Hit test: 11-bit differences so a beam left of / above the sprite goes negative
    // instead of wrapping; nothing past coordinate 1023 is ever reached, so clipping is free.
    always_comb begin
        dx     = {1'b0, hcount} - {1'b0, act_x_q};
        dy     = {1'b0, vcount} - {1'b0, act_y_q};
        in_box = act_en_q & ~blank
               & ~dx[10] & (dx < SprW)
               & ~dy[10] & (dy < SprH);
    end

    // ROM address holds its previous value outside the box to avoid needless toggling
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (in_box) begin
            rom_addr_d = {dy[SPR_H_LOG2-1:0], dx[SPR_W_LOG2-1:0]};
        end
    end

    // Stage 1 and stage 2 registers; blank resets high so outputs read as blanked
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q  <= '0;
            s1_in_box_q <= 1'b0;
            s1_bg_q     <= '0;
            s1_blank_q  <= 1'b1;
            s2_in_box_q <= 1'b0;
            s2_bg_q     <= '0;
            s2_blank_q  <= 1'b1;
        end else begin
            rom_addr_q  <= rom_addr_d;
            s1_in_box_q <= in_box;
            s1_bg_q     <= bg_pixel;
            s1_blank_q  <= blank;
            s2_in_box_q <= s1_in_box_q;
            s2_bg_q     <= s1_bg_q;
            s2_blank_q  <= s1_blank_q;
        end
    end

    // Stage 3 merge: rom_data is aligned with the stage 2 registers
    always_comb begin
        opaque    = s2_in_box_q & (rom_data != TRANSPARENT);
        pix_out_d = opaque ? rom_data : s2_bg_q;
        spr_hit_d = opaque & ~s2_blank_q;
        if (s2_blank_q) begin
            pix_out_d = '0;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out_q   <= '0;
            pix_blank_q <= 1'b1;
            spr_hit_q   <= 1'b0;
        end else begin
            pix_out_q   <= pix_out_d;
            pix_blank_q <= s2_blank_q;
            spr_hit_q   <= spr_hit_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_out   = pix_out_q;
    assign pix_blank = pix_blank_q;
    assign spr_hit   = spr_hit_q;

endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for sprite_render with a behavioural 1-cycle sprite ROM.
module tb_sprite_render;

    logic       clk;
    logic       rst;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       blank;
    logic       frame_start;
    logic [7:0] bg_pixel;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       pos_load;
    logic       spr_en;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] pix_out;
    logic       pix_blank;
    logic       spr_hit;

    int passed;
    int total;

    sprite_render dut (
        .clk        (clk),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .blank      (blank),
        .frame_start(frame_start),
        .bg_pixel   (bg_pixel),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_load   (pos_load),
        .spr_en     (spr_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_out    (pix_out),
        .pix_blank  (pix_blank),
        .spr_hit    (spr_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM contents: texel 5 is the transparent key, no other texel equals it
    function automatic logic [7:0] tex(input int a);
        logic [7:0] v;
        if (a == 5) return 8'hE3;
        v = 8'((a * 37 + 11) & 255);
        if (v == 8'hE3) v = 8'h1C;
        return v;
    endfunction

    always @(posedge clk) rom_data <= tex(int'(rom_addr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       blk;
        logic [7:0] bg;
        logic       chk_addr;
        logic [9:0] exp_addr;
        logic [7:0] exp_pix;
        logic       exp_hit;
    } vec_t;

    vec_t vecs[32];
    int   nv;

    task automatic add(input int h, input int v, input logic blk, input logic chk,
                       input int addr, input logic hit);
        logic [7:0] bg;
        bg = 8'(8'h40 + nv);
        vecs[nv].h        = 10'(h);
        vecs[nv].v        = 10'(v);
        vecs[nv].blk      = blk;
        vecs[nv].bg       = bg;
        vecs[nv].chk_addr = chk;
        vecs[nv].exp_addr = 10'(addr);
        vecs[nv].exp_hit  = hit;
        vecs[nv].exp_pix  = blk ? 8'h00 : (hit ? tex(addr) : bg);
        nv++;
    endtask

    task automatic set_pos(input int x, input int y, input logic en, input logic ld,
                           input logic fs);
        @(negedge clk);
        pos_x       = 10'(x);
        pos_y       = 10'(y);
        spr_en      = en;
        pos_load    = ld;
        frame_start = fs;
        @(negedge clk);
        pos_load    = 1'b0;
        frame_start = 1'b0;
    endtask

    // Each vector is held for three clocks, then the aligned output is sampled
    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            hcount   = vecs[i].h;
            vcount   = vecs[i].v;
            blank    = vecs[i].blk;
            bg_pixel = vecs[i].bg;
            @(posedge clk); #1;
            if (vecs[i].chk_addr)
                check($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
            @(posedge clk);
            @(posedge clk); #1;
            check($sformatf("vec%0d pix_out", i), 32'(pix_out), 32'(vecs[i].exp_pix));
            check($sformatf("vec%0d spr_hit", i), 32'(spr_hit), 32'(vecs[i].exp_hit));
            check($sformatf("vec%0d pix_blank", i), 32'(pix_blank), 32'(vecs[i].blk));
        end
    endtask

    // Streams line 50, x=95..135, one pixel per clock; sprite assumed at (100,50) if en
    task automatic stream_line(input logic en, input string tag);
        logic [7:0] e_pix[41];
        logic       e_hit[41];
        for (int k = 0; k < 41 + 2; k++) begin
            @(negedge clk);
            if (k < 41) begin
                hcount   = 10'(95 + k);
                vcount   = 10'd50;
                blank    = 1'b0;
                bg_pixel = 8'(8'h90 + k);
                e_hit[k] = en && (95 + k >= 100) && (95 + k <= 131) && (95 + k != 105);
                e_pix[k] = e_hit[k] ? tex(95 + k - 100) : bg_pixel;
            end
            @(posedge clk); #1;
            if (k >= 2) begin
                check($sformatf("%s x%0d pix", tag, 95 + k - 2), 32'(pix_out),
                      32'(e_pix[k - 2]));
                check($sformatf("%s x%0d hit", tag, 95 + k - 2), 32'(spr_hit),
                      32'(e_hit[k - 2]));
            end
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        nv     = 0;
        rst = 1'b1; hcount = '0; vcount = '0; blank = 1'b1; frame_start = 1'b0;
        bg_pixel = '0; pos_x = '0; pos_y = '0; pos_load = 1'b0; spr_en = 1'b0;

        // Vector tables
        add( 99, 50, 0, 0,   0, 0);   // 0  left of box
        add(100, 50, 0, 1,   0, 1);   // 1  top-left texel
        add(131, 50, 0, 1,  31, 1);   // 2  right edge
        add(132, 50, 0, 0,   0, 0);   // 3  past right edge
        add(105, 50, 0, 1,   5, 0);   // 4  transparent texel
        add(100, 49, 0, 0,   0, 0);   // 5  above box
        add(100, 81, 0, 1, 992, 1);   // 6  bottom row
        add(100, 82, 0, 0,   0, 0);   // 7  below box
        add(110, 60, 0, 1, 330, 1);   // 8  interior
        add(110, 60, 1, 0,   0, 0);   // 9  blank inside box
        add(100, 50, 0, 1,   0, 1);   // 10 shadow load alone: old pos
        add(200, 80, 0, 0,   0, 0);   // 11
        add(300,100, 0, 1,   0, 1);   // 12 load+frame_start: new pos
        add(100, 50, 0, 0,   0, 0);   // 13
        add(200, 80, 0, 0,   0, 0);   // 14
        add(331,131, 0, 1,1023, 1);   // 15 frame_start alone keeps (300,100)
        add(1010,470,0, 1,   0, 1);   // 16 edge sprite
        add(1023,501,0, 1,1005, 1);   // 17 last visible texel
        add(  0,470, 0, 0,   0, 0);   // 18 no x wrap
        add(  5,  0, 0, 0,   0, 0);   // 19 no y wrap
        add(1023,502,0, 0,   0, 0);   // 20 below clipped sprite
        add(1015,480,1, 0,   0, 0);   // 21 blank

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        check("reset pix_out", 32'(pix_out), 32'd0);
        check("reset pix_blank", 32'(pix_blank), 32'd1);
        check("reset spr_hit", 32'(spr_hit), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        set_pos(100, 50, 1'b1, 1'b1, 1'b1);
        run_range(0, 9);
        stream_line(1'b1, "line50");

        set_pos(200, 80, 1'b1, 1'b1, 1'b0);
        run_range(10, 11);
        set_pos(300, 100, 1'b1, 1'b1, 1'b1);
        run_range(12, 14);
        set_pos(0, 0, 1'b1, 1'b0, 1'b1);
        run_range(15, 15);

        set_pos(1010, 470, 1'b1, 1'b1, 1'b1);
        run_range(16, 21);

        // Reset mid-line with the beam inside the sprite
        set_pos(100, 50, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        hcount = 10'd110; vcount = 10'd50; blank = 1'b0; bg_pixel = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset hit", 32'(spr_hit), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst rom_addr", 32'(rom_addr), 32'd0);
        check("midrst pix_out", 32'(pix_out), 32'd0);
        check("midrst pix_blank", 32'(pix_blank), 32'd1);
        check("midrst spr_hit", 32'(spr_hit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("postrst pix_out", 32'(pix_out), 32'h77);
        check("postrst spr_hit", 32'(spr_hit), 32'd0);
        // frame_start without a load uses the cleared shadow (0,0): still off (110,50)
        set_pos(100, 50, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        hcount = 10'd110; vcount = 10'd50; blank = 1'b0; bg_pixel = 8'h78;
        repeat (3) @(posedge clk);
        #1;
        check("fs-noload pix_out", 32'(pix_out), 32'h78);
        check("fs-noload spr_hit", 32'(spr_hit), 32'd0);
        set_pos(100, 50, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        hcount = 10'd110; vcount = 10'd50;
        repeat (3) @(posedge clk);
        #1;
        check("reload pix_out", 32'(pix_out), 32'(tex(10)));
        check("reload spr_hit", 32'(spr_hit), 32'd1);

        // Sprite disabled for a frame
        set_pos(100, 50, 1'b0, 1'b1, 1'b1);
        stream_line(1'b0, "disabled");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "timeout");
    end

endmodule
